// File: rtl/ahblite_pid_pkg.sv
// Shared definitions for the AHB-Lite PID peripheral: register map,
// control/status bit positions, sequencer states and datapath sizing.
package ahblite_pid_pkg;

  // Word offsets decoded from HADDR[4:2]
  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_STATUS   = 3'd1;
  localparam logic [2:0] OFF_KP       = 3'd2;
  localparam logic [2:0] OFF_KI       = 3'd3;
  localparam logic [2:0] OFF_KD       = 3'd4;
  localparam logic [2:0] OFF_SETPOINT = 3'd5;
  localparam logic [2:0] OFF_FEEDBACK = 3'd6;
  localparam logic [2:0] OFF_OUTPUT   = 3'd7;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_SAT  = 2;

  // One state per cycle of the PID update; IDLE is the only non-busy state
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ERR   = 3'd1,
    ST_MUL_P = 3'd2,
    ST_MUL_I = 3'd3,
    ST_MUL_D = 3'd4,
    ST_SUM   = 3'd5
  } pid_state_t;

  // Widest product is DATA_W x (DATA_W+2); three of them summed need two
  // more guard bits so the accumulator can never wrap.
  function automatic int acc_width(input int data_w);
    return 2 * data_w + 4;
  endfunction

endpackage

// File: rtl/pid_datapath.sv
// PID arithmetic: error/integral/derivative terms, one shared multiplier,
// the wide accumulator and the integral/output saturation logic.
// The phase input is the sequencer state of the owning slave.
module pid_datapath
  import ahblite_pid_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FRAC    = 8,
  parameter int INT_LIM = 32767
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  pid_state_t               phase,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] kp,
  input  logic signed [DATA_W-1:0] ki,
  input  logic signed [DATA_W-1:0] kd,
  input  logic signed [DATA_W-1:0] setpoint,
  input  logic signed [DATA_W-1:0] feedback,
  output logic signed [DATA_W-1:0] out_val,
  output logic                     sat_hit
);

  localparam int E_W   = DATA_W + 1;
  localparam int S_W   = DATA_W + 2;
  localparam int P_W   = DATA_W + S_W;
  localparam int ACC_W = acc_width(DATA_W);

  localparam logic signed [S_W-1:0] LIM_P = S_W'(INT_LIM);
  localparam logic signed [S_W-1:0] LIM_N = -LIM_P;

  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [E_W-1:0]    e_r;
  logic signed [E_W-1:0]    e_prev_r;
  logic signed [E_W-1:0]    integ_r;
  logic signed [S_W-1:0]    d_r;
  logic                     int_sat_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [DATA_W-1:0] out_r;

  logic signed [E_W-1:0]    e_next;
  logic signed [E_W-1:0]    integ_next;
  logic signed [S_W-1:0]    isum;
  logic signed [S_W-1:0]    d_next;
  logic                     int_clamp;

  logic signed [DATA_W-1:0] mul_a;
  logic signed [S_W-1:0]    mul_b;
  logic signed [P_W-1:0]    product;

  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] out_next;
  logic                     out_clamp;

  // Error, clamped integral and derivative terms evaluated in the ERR cycle
  always_comb begin
    e_next     = E_W'(setpoint) - E_W'(feedback);
    isum       = S_W'(integ_r) + S_W'(e_next);
    d_next     = S_W'(e_next) - S_W'(e_prev_r);
    int_clamp  = 1'b0;
    integ_next = E_W'(isum);
    if (isum > LIM_P) begin
      integ_next = E_W'(LIM_P);
      int_clamp  = 1'b1;
    end else if (isum < LIM_N) begin
      integ_next = E_W'(LIM_N);
      int_clamp  = 1'b1;
    end
  end

  // Operand select for the single shared multiplier
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (phase)
      ST_MUL_P: begin
        mul_a = kp;
        mul_b = S_W'(e_r);
      end
      ST_MUL_I: begin
        mul_a = ki;
        mul_b = S_W'(integ_r);
      end
      ST_MUL_D: begin
        mul_a = kd;
        mul_b = d_r;
      end
      default: ;
    endcase
    product = P_W'(mul_a) * P_W'(mul_b);
  end

  // Drop the fractional bits (floor) and clamp into the signed output range
  always_comb begin
    shifted   = acc_r >>> FRAC;
    out_clamp = 1'b0;
    out_next  = DATA_W'(shifted);
    if (shifted > OUT_MAX) begin
      out_next  = DATA_W'(OUT_MAX);
      out_clamp = 1'b1;
    end else if (shifted < OUT_MIN) begin
      out_next  = DATA_W'(OUT_MIN);
      out_clamp = 1'b1;
    end
  end

  // Step the datapath registers according to the current phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_r       <= '0;
      e_prev_r  <= '0;
      integ_r   <= '0;
      d_r       <= '0;
      int_sat_r <= 1'b0;
      acc_r     <= '0;
      out_r     <= '0;
    end else begin
      if (clr) begin
        integ_r  <= '0;
        e_prev_r <= '0;
      end
      case (phase)
        ST_ERR: begin
          e_r       <= e_next;
          integ_r   <= integ_next;
          d_r       <= d_next;
          int_sat_r <= int_clamp;
        end
        ST_MUL_P: acc_r <= ACC_W'(product);
        ST_MUL_I: acc_r <= acc_r + ACC_W'(product);
        ST_MUL_D: acc_r <= acc_r + ACC_W'(product);
        ST_SUM: begin
          out_r    <= out_next;
          e_prev_r <= e_r;
        end
        default: ;
      endcase
    end
  end

  assign out_val = out_r;
  assign sat_hit = int_sat_r | out_clamp;

endmodule

// File: rtl/ahblite_pid_slave.sv
// AHB-Lite slave wrapping a memory-mapped PID controller. A FEEDBACK write
// with EN set launches a five-cycle update; register accesses that would
// disturb or observe the update in flight are held off with wait states.
module ahblite_pid_slave
  import ahblite_pid_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FRAC    = 8,
  parameter int INT_LIM = 32767
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        irq
);

  pid_state_t state;
  pid_state_t state_next;

  logic       dp_active;
  logic       dp_write;
  logic [2:0] dp_off;

  logic       accept;
  logic       stall_access;
  logic       wr_en;
  logic       w1c;
  logic       clr;
  logic       start;
  logic       busy;
  logic       done_set;
  logic       sat_hit;

  logic                     ctrl_en;
  logic                     ctrl_irq_en;
  logic                     status_done;
  logic                     status_sat;
  logic signed [DATA_W-1:0] kp;
  logic signed [DATA_W-1:0] ki;
  logic signed [DATA_W-1:0] kd;
  logic signed [DATA_W-1:0] setpoint;
  logic signed [DATA_W-1:0] feedback;
  logic signed [DATA_W-1:0] out_val;
  logic signed [DATA_W-1:0] wdata;

  logic unused_ok;
  assign unused_ok = ^{HSIZE, HPROT, HADDR[31:5], HADDR[1:0], HTRANS[0],
                       HWDATA[31:DATA_W]};

  assign accept       = HSEL & HTRANS[1] & HREADY;
  assign stall_access = dp_active &
                        (( dp_write & (dp_off != OFF_STATUS) & (dp_off != OFF_OUTPUT)) |
                         (!dp_write & (dp_off == OFF_OUTPUT)));
  assign HREADYOUT    = !(busy & stall_access);
  assign wr_en        = dp_active & dp_write & HREADYOUT;
  assign w1c          = wr_en & (dp_off == OFF_STATUS);
  assign clr          = wr_en & (dp_off == OFF_CTRL) & HWDATA[CTRL_CLR];
  assign start        = wr_en & (dp_off == OFF_FEEDBACK) & ctrl_en;
  assign wdata        = HWDATA[DATA_W-1:0];
  assign HRESP        = 1'b0;
  assign irq          = status_done & ctrl_irq_en;

  // Track the data phase that follows an accepted address phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_active <= 1'b0;
      dp_write  <= 1'b0;
      dp_off    <= '0;
    end else if (accept) begin
      dp_active <= 1'b1;
      dp_write  <= HWRITE;
      dp_off    <= HADDR[4:2];
    end else if (HREADYOUT) begin
      dp_active <= 1'b0;
    end
  end

  // Sequencer state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Sequencer next state: a fixed walk through the five update cycles
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_ERR;
      ST_ERR:   state_next = ST_MUL_P;
      ST_MUL_P: state_next = ST_MUL_I;
      ST_MUL_I: state_next = ST_MUL_D;
      ST_MUL_D: state_next = ST_SUM;
      ST_SUM:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Sequencer outputs: busy flag and end-of-update strobe
  always_comb begin
    busy     = (state != ST_IDLE);
    done_set = (state == ST_SUM);
  end

  // Writable configuration registers, updated when the write data phase completes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      kp          <= '0;
      ki          <= '0;
      kd          <= '0;
      setpoint    <= '0;
      feedback    <= '0;
    end else if (wr_en) begin
      case (dp_off)
        OFF_CTRL: begin
          ctrl_en     <= HWDATA[CTRL_EN];
          ctrl_irq_en <= HWDATA[CTRL_IRQ_EN];
        end
        OFF_KP:       kp       <= wdata;
        OFF_KI:       ki       <= wdata;
        OFF_KD:       kd       <= wdata;
        OFF_SETPOINT: setpoint <= wdata;
        OFF_FEEDBACK: feedback <= wdata;
        default: ;
      endcase
    end
  end

  // Sticky DONE/SAT flags; a hardware set beats a simultaneous write-one-to-clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      status_done <= 1'b0;
      status_sat  <= 1'b0;
    end else begin
      status_done <= done_set | (status_done & !(w1c & HWDATA[STAT_DONE]));
      status_sat  <= (done_set & sat_hit) | (status_sat & !(w1c & HWDATA[STAT_SAT]));
    end
  end

  // Read mux, driven only during a read data phase
  always_comb begin
    HRDATA = '0;
    if (dp_active && !dp_write) begin
      case (dp_off)
        OFF_CTRL:     HRDATA = 32'({ctrl_irq_en, 1'b0, ctrl_en});
        OFF_STATUS:   HRDATA = 32'({status_sat, status_done, busy});
        OFF_KP:       HRDATA = 32'(kp);
        OFF_KI:       HRDATA = 32'(ki);
        OFF_KD:       HRDATA = 32'(kd);
        OFF_SETPOINT: HRDATA = 32'(setpoint);
        OFF_FEEDBACK: HRDATA = 32'(feedback);
        OFF_OUTPUT:   HRDATA = 32'(out_val);
        default:      HRDATA = '0;
      endcase
    end
  end

  pid_datapath #(
    .DATA_W  (DATA_W),
    .FRAC    (FRAC),
    .INT_LIM (INT_LIM)
  ) u_datapath (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .phase    (state),
    .clr      (clr),
    .kp       (kp),
    .ki       (ki),
    .kd       (kd),
    .setpoint (setpoint),
    .feedback (feedback),
    .out_val  (out_val),
    .sat_hit  (sat_hit)
  );

endmodule
